// File: rtl/dmem_port_arbiter_if.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter_if
//  Brief    : One requester channel into the data-memory port arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
interface dmem_port_arbiter_if #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
);
  logic              req;
  logic              we;
  logic [2:0]        funct3;
  logic [ADDR_W-1:0] addr;
  logic [DATA_W-1:0] wdata;
  logic              ack;
  logic [DATA_W-1:0] rdata;

  modport master (output req, we, funct3, addr, wdata, input ack, rdata);
  modport slave  (input req, we, funct3, addr, wdata, output ack, rdata);
endinterface
`default_nettype wire

// File: rtl/dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : dmem_port_arbiter
//  Brief    : Round-robin arbiter sharing the data memory between core and debug.
//  Revision : 1.0 - initial release
// ============================================================================
module dmem_port_arbiter #(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32
) (
  input  wire                clk_i,
  input  wire                rst_ni,
  dmem_port_arbiter_if.slave c_if,
  dmem_port_arbiter_if.slave d_if,
  output logic               c_stall_o,
  output logic               m_we_o,
  output logic [2:0]         m_funct3_o,
  output logic [ADDR_W-1:0]  m_addr_o,
  output logic [DATA_W-1:0]  m_wdata_o,
  input  wire [DATA_W-1:0]   m_rdata_i,
  output logic               busy_o
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RESP   = 2'd2
  } state_e;

  localparam logic SEL_C = 1'b0;
  localparam logic SEL_D = 1'b1;

  state_e            state_q, state_d;
  logic              last_grant_q, last_grant_d;
  logic              sel_q, sel_d;
  logic              we_q, we_d;
  logic [2:0]        m_funct3_q, m_funct3_d;
  logic [ADDR_W-1:0] m_addr_q, m_addr_d;
  logic [DATA_W-1:0] m_wdata_q, m_wdata_d;
  logic [DATA_W-1:0] c_rdata_q, c_rdata_d;
  logic [DATA_W-1:0] d_rdata_q, d_rdata_d;
  logic              grant_sel;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_q      <= IDLE;
      last_grant_q <= SEL_D;  // so the core wins the first tie
      sel_q        <= SEL_C;
      we_q         <= 1'b0;
      m_funct3_q   <= '0;
      m_addr_q     <= '0;
      m_wdata_q    <= '0;
      c_rdata_q    <= '0;
      d_rdata_q    <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      sel_q        <= sel_d;
      we_q         <= we_d;
      m_funct3_q   <= m_funct3_d;
      m_addr_q     <= m_addr_d;
      m_wdata_q    <= m_wdata_d;
      c_rdata_q    <= c_rdata_d;
      d_rdata_q    <= d_rdata_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    sel_d        = sel_q;
    we_d         = we_q;
    m_funct3_d   = m_funct3_q;
    m_addr_d     = m_addr_q;
    m_wdata_d    = m_wdata_q;
    c_rdata_d    = c_rdata_q;
    d_rdata_d    = d_rdata_q;
    grant_sel    = (c_if.req && d_if.req) ? ~last_grant_q : d_if.req;

    case (state_q)
      IDLE: begin
        if (c_if.req || d_if.req) begin
          sel_d        = grant_sel;
          last_grant_d = grant_sel;
          we_d         = (grant_sel == SEL_D) ? d_if.we     : c_if.we;
          m_funct3_d   = (grant_sel == SEL_D) ? d_if.funct3 : c_if.funct3;
          m_addr_d     = (grant_sel == SEL_D) ? d_if.addr   : c_if.addr;
          m_wdata_d    = (grant_sel == SEL_D) ? d_if.wdata  : c_if.wdata;
          state_d      = ACCESS;
        end
      end
      ACCESS: begin
        // Read data is captured for stores too; the requester simply ignores it.
        if (sel_q == SEL_D) d_rdata_d = m_rdata_i;
        else                c_rdata_d = m_rdata_i;
        state_d = RESP;
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Reset gating kills the write and the ack in the very cycle reset is applied.
  assign m_we_o     = (state_q == ACCESS) && we_q && rst_ni;
  assign c_if.ack   = (state_q == RESP) && (sel_q == SEL_C) && rst_ni;
  assign d_if.ack   = (state_q == RESP) && (sel_q == SEL_D) && rst_ni;
  assign c_if.rdata = c_rdata_q;
  assign d_if.rdata = d_rdata_q;
  assign c_stall_o  = c_if.req && !c_if.ack;
  assign busy_o     = (state_q != IDLE);
  assign m_funct3_o = m_funct3_q;
  assign m_addr_o   = m_addr_q;
  assign m_wdata_o  = m_wdata_q;

endmodule
`default_nettype wire

// File: tb/tb_dmem_port_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_dmem_port_arbiter
//  Brief    : Directed and randomized checks of dmem_port_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_dmem_port_arbiter;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        c_stall, m_we, busy;
  logic [2:0]  m_funct3;
  logic [31:0] m_addr, m_wdata, m_rdata;

  logic [31:0] mem [256];
  logic        mem_init = 1'b1;
  logic        pre_en = 1'b0;
  logic [7:0]  pre_idx = '0;
  logic [31:0] pre_val = '0;
  logic [31:0] ref_mem [256];

  int checks = 0;
  int failures = 0;

  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) c_bus ();
  dmem_port_arbiter_if #(.ADDR_W(32), .DATA_W(32)) d_bus ();

  dmem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
    .clk_i      (clk),
    .rst_ni     (rst_n),
    .c_if       (c_bus),
    .d_if       (d_bus),
    .c_stall_o  (c_stall),
    .m_we_o     (m_we),
    .m_funct3_o (m_funct3),
    .m_addr_o   (m_addr),
    .m_wdata_o  (m_wdata),
    .m_rdata_i  (m_rdata),
    .busy_o     (busy)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(int i);
    return 32'hA5A5_0000 | 32'(i);
  endfunction

  // Word-wide memory: combinational read, write on the rising edge.
  assign m_rdata = mem[m_addr[9:2]];
  always @(posedge clk) begin
    if (mem_init) begin
      for (int i = 0; i < 256; i++) mem[i] <= init_word(i);
    end else if (m_we) begin
      mem[m_addr[9:2]] <= m_wdata;
    end else if (pre_en) begin
      mem[pre_idx] <= pre_val;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_reqs();
    c_bus.req = 0; c_bus.we = 0; c_bus.funct3 = 0; c_bus.addr = 0; c_bus.wdata = 0;
    d_bus.req = 0; d_bus.we = 0; d_bus.funct3 = 0; d_bus.addr = 0; d_bus.wdata = 0;
  endtask

  task automatic test_reset();
    clear_reqs();
    rst_n = 0;
    repeat (2) tick();
    mem_init = 0;
    rst_n = 1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      checks++;
      if ({busy, m_we, c_bus.ack, d_bus.ack, c_stall} !== 5'b0) begin
        failures++;
        $display("FAIL reset_ctrl cyc%0d: got {busy,we,cack,dack,stall}=%b want 00000", k,
                 {busy, m_we, c_bus.ack, d_bus.ack, c_stall});
      end
      checks++;
      if ({c_bus.rdata, d_bus.rdata, m_addr, m_wdata, m_funct3} !== 131'b0) begin
        failures++;
        $display("FAIL reset_data cyc%0d: got crd=%h drd=%h addr=%h wd=%h f3=%b want all 0", k,
                 c_bus.rdata, d_bus.rdata, m_addr, m_wdata, m_funct3);
      end
    end
  endtask

  task automatic test_core_store();
    tick();
    c_bus.req = 1; c_bus.we = 1; c_bus.addr = 32'h10; c_bus.wdata = 32'hDEADBEEF; c_bus.funct3 = 3'b010;
    @(negedge clk);
    checks++;
    if ({c_stall, m_we, busy, c_bus.ack, d_bus.ack} !== 5'b10000) begin
      failures++;
      $display("FAIL store_N: got {stall,we,busy,cack,dack}=%b want 10000",
               {c_stall, m_we, busy, c_bus.ack, d_bus.ack});
    end
    @(negedge clk);
    checks++;
    if ({c_stall, m_we, busy, c_bus.ack, d_bus.ack} !== 5'b11100) begin
      failures++;
      $display("FAIL store_N1: got {stall,we,busy,cack,dack}=%b want 11100",
               {c_stall, m_we, busy, c_bus.ack, d_bus.ack});
    end
    checks++;
    if (m_addr !== 32'h10 || m_wdata !== 32'hDEADBEEF || m_funct3 !== 3'b010) begin
      failures++;
      $display("FAIL store_bus: got addr=%h wd=%h f3=%b want 00000010 deadbeef 010",
               m_addr, m_wdata, m_funct3);
    end
    @(negedge clk);
    checks++;
    if ({c_stall, m_we, busy, c_bus.ack, d_bus.ack} !== 5'b00110) begin
      failures++;
      $display("FAIL store_N2: got {stall,we,busy,cack,dack}=%b want 00110",
               {c_stall, m_we, busy, c_bus.ack, d_bus.ack});
    end
    checks++;
    if (c_bus.rdata !== init_word(4)) begin
      failures++;
      $display("FAIL store_rdata: got %h want %h", c_bus.rdata, init_word(4));
    end
    tick();
    c_bus.req = 0;
    @(negedge clk);
    checks++;
    if ({busy, m_we, c_bus.ack, d_bus.ack} !== 4'b0 || mem[4] !== 32'hDEADBEEF || m_addr !== 32'h10) begin
      failures++;
      $display("FAIL store_N3: got {busy,we,cack,dack}=%b mem=%h addr=%h want 0000 deadbeef 10",
               {busy, m_we, c_bus.ack, d_bus.ack}, mem[4], m_addr);
    end
  endtask

  task automatic test_debug_load();
    tick();
    pre_en = 1; pre_idx = 8'd8; pre_val = 32'h12345678;
    tick();
    pre_en = 0;
    d_bus.req = 1; d_bus.we = 0; d_bus.addr = 32'h20; d_bus.funct3 = 3'b010; d_bus.wdata = 32'hFFFF0000;
    @(negedge clk);
    @(negedge clk);
    checks++;
    if (m_we !== 1'b0 || m_addr !== 32'h20 || busy !== 1'b1 || c_stall !== 1'b0) begin
      failures++;
      $display("FAIL load_N1: got we=%b addr=%h busy=%b stall=%b want 0 20 1 0", m_we, m_addr, busy, c_stall);
    end
    @(negedge clk);
    checks++;
    if ({c_bus.ack, d_bus.ack} !== 2'b01 || d_bus.rdata !== 32'h12345678) begin
      failures++;
      $display("FAIL load_N2: got {cack,dack}=%b drd=%h want 01 12345678", {c_bus.ack, d_bus.ack}, d_bus.rdata);
    end
    tick();
    d_bus.req = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (d_bus.ack !== 1'b0 || d_bus.rdata !== 32'h12345678 || c_bus.rdata !== init_word(4)) begin
        failures++;
        $display("FAIL load_hold%0d: got dack=%b drd=%h crd=%h want 0 12345678 %h",
                 k, d_bus.ack, d_bus.rdata, c_bus.rdata, init_word(4));
      end
    end
  endtask

  task automatic test_round_robin();
    logic ec, ed;
    tick();
    rst_n = 0;
    c_bus.req = 1; c_bus.we = 0; c_bus.addr = 32'h100;
    d_bus.req = 1; d_bus.we = 0; d_bus.addr = 32'h200;
    tick();
    rst_n = 1;
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      ec = (k % 3 == 2) && ((k / 3) % 2 == 0);
      ed = (k % 3 == 2) && ((k / 3) % 2 == 1);
      checks++;
      if (c_bus.ack !== ec || d_bus.ack !== ed) begin
        failures++;
        $display("FAIL rr_k%0d: got {cack,dack}=%b%b want %b%b", k, c_bus.ack, d_bus.ack, ec, ed);
      end
    end
    tick();
    clear_reqs();
    repeat (2) @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      failures++;
      $display("FAIL rr_idle: got busy=%b want 0", busy);
    end
  endtask

  task automatic test_reset_in_access();
    tick();
    c_bus.req = 1; c_bus.we = 1; c_bus.addr = 32'h40; c_bus.wdata = 32'hCAFEF00D; c_bus.funct3 = 3'b010;
    tick();
    rst_n = 0;
    @(negedge clk);
    checks++;
    if (m_we !== 1'b0 || m_wdata !== 32'hCAFEF00D || busy !== 1'b1 || c_bus.ack !== 1'b0) begin
      failures++;
      $display("FAIL rstacc_N1: got we=%b wd=%h busy=%b cack=%b want 0 cafef00d 1 0",
               m_we, m_wdata, busy, c_bus.ack);
    end
    tick();
    rst_n = 1;
    c_bus.req = 0;
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || c_bus.ack !== 1'b0 || mem[16] !== init_word(16) || m_wdata !== 32'h0) begin
        failures++;
        $display("FAIL rstacc_after%0d: got busy=%b cack=%b mem=%h wd=%h want 0 0 %h 0",
                 k, busy, c_bus.ack, mem[16], m_wdata, init_word(16));
      end
    end
  endtask

  task automatic test_req_drop();
    tick();
    c_bus.req = 1; c_bus.we = 0; c_bus.addr = 32'h10; c_bus.funct3 = 3'b010;
    tick();
    c_bus.req = 0; c_bus.addr = 32'h80;
    @(negedge clk);
    checks++;
    if ({c_stall, m_we, busy, c_bus.ack} !== 4'b0010 || m_addr !== 32'h10) begin
      failures++;
      $display("FAIL drop_N1: got {stall,we,busy,cack}=%b addr=%h want 0010 10",
               {c_stall, m_we, busy, c_bus.ack}, m_addr);
    end
    @(negedge clk);
    checks++;
    if (c_bus.ack !== 1'b1 || c_bus.rdata !== 32'hDEADBEEF) begin
      failures++;
      $display("FAIL drop_N2: got cack=%b crd=%h want 1 deadbeef", c_bus.ack, c_bus.rdata);
    end
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      checks++;
      if (busy !== 1'b0 || c_bus.ack !== 1'b0) begin
        failures++;
        $display("FAIL drop_idle%0d: got busy=%b cack=%b want 0 0", k, busy, c_bus.ack);
      end
    end
  endtask

  // Transaction-level model: a grant happens whenever the port is free and someone
  // asks; the winner acks two cycles later and the port frees up the cycle after.
  task automatic test_random();
    int          free_c = 0, ack_c = -1, gnt_c = -10;
    logic        ack_w = 0, last_w = 1, g_we = 0, w, c_pend = 0, d_pend = 0, ec, ed;
    logic [31:0] g_addr = 0, pend_r = 0, exp_cr = 0, exp_dr = 0;
    logic [7:0]  idx;
    tick();
    mem_init = 1; rst_n = 0;
    clear_reqs();
    tick();
    mem_init = 0;
    tick();
    rst_n = 1;
    for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
    for (int cyc = 0; cyc < 400; cyc++) begin
      @(negedge clk);
      ec = (cyc == ack_c) && !ack_w;
      ed = (cyc == ack_c) && ack_w;
      if (ec) exp_cr = pend_r;
      if (ed) exp_dr = pend_r;
      checks++;
      if (c_bus.ack !== ec || d_bus.ack !== ed) begin
        failures++;
        $display("FAIL rnd_ack c%0d: got {cack,dack}=%b%b want %b%b", cyc, c_bus.ack, d_bus.ack, ec, ed);
      end
      checks++;
      if (busy !== (cyc < free_c) || m_we !== ((cyc == gnt_c + 1) && g_we)) begin
        failures++;
        $display("FAIL rnd_ctrl c%0d: got busy=%b we=%b want %b %b", cyc, busy, m_we,
                 (cyc < free_c), ((cyc == gnt_c + 1) && g_we));
      end
      checks++;
      if (c_stall !== (c_bus.req && !ec)) begin
        failures++;
        $display("FAIL rnd_stall c%0d: got %b want %b", cyc, c_stall, (c_bus.req && !ec));
      end
      checks++;
      if (c_bus.rdata !== exp_cr || d_bus.rdata !== exp_dr) begin
        failures++;
        $display("FAIL rnd_rdata c%0d: got c=%h d=%h want c=%h d=%h", cyc, c_bus.rdata, d_bus.rdata, exp_cr, exp_dr);
      end
      if (cyc == gnt_c + 1) begin
        checks++;
        if (m_addr !== g_addr) begin
          failures++;
          $display("FAIL rnd_addr c%0d: got %h want %h", cyc, m_addr, g_addr);
        end
      end
      if (cyc >= free_c && (c_bus.req || d_bus.req)) begin
        w      = (c_bus.req && d_bus.req) ? !last_w : d_bus.req;
        last_w = w;
        g_we   = w ? d_bus.we : c_bus.we;
        g_addr = w ? d_bus.addr : c_bus.addr;
        idx    = g_addr[9:2];
        pend_r = ref_mem[idx];
        if (g_we) ref_mem[idx] = w ? d_bus.wdata : c_bus.wdata;
        gnt_c = cyc; ack_c = cyc + 2; ack_w = w; free_c = cyc + 3;
      end
      if (ec) c_pend = 0;
      if (ed) d_pend = 0;
      tick();
      if (!c_pend) begin
        c_pend = ($urandom_range(0, 2) != 0);
        c_bus.req = c_pend; c_bus.we = 1'($urandom); c_bus.funct3 = 3'($urandom);
        c_bus.addr = {22'b0, 1'b0, 7'($urandom), 2'b00}; c_bus.wdata = $urandom;
      end
      if (!d_pend) begin
        d_pend = ($urandom_range(0, 2) != 0);
        d_bus.req = d_pend; d_bus.we = 1'($urandom); d_bus.funct3 = 3'($urandom);
        d_bus.addr = {22'b0, 1'b1, 7'($urandom), 2'b00}; d_bus.wdata = $urandom;
      end
    end
    clear_reqs();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, checks=%0d failures=%0d", checks, failures);
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_core_store();
    test_debug_load();
    test_round_robin();
    test_reset_in_access();
    test_req_drop();
    test_random();
    repeat (3) tick();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
